ac_ctrl: RTL and testbench



---
 rtl/ac_ctrl.sv | 153 +++++++++++++++
 tb/tb_ac_ctrl.sv | 295 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ac_ctrl.sv
// Fetch/decode/execute sequencer for the Sim-AC accumulator machine.
// Sole master of the 32x8 program/data RAM; holds pc, ir, acc and Z/C flags.
module ac_ctrl #(
    parameter int unsigned ADDR_W = 5,
    parameter int unsigned DATA_W = 8
) (
    input  logic              clk_i,
    input  logic              rst_ni,
    input  logic              run_i,
    input  logic [DATA_W-1:0] mem_dout_i,
    output logic [ADDR_W-1:0] mem_addr_o,
    output logic              mem_wen_o,
    output logic [DATA_W-1:0] mem_din_o,
    output logic [DATA_W-1:0] acc_o,
    output logic [ADDR_W-1:0] pc_o,
    output logic              z_o,
    output logic              c_o,
    output logic              halted_o
);

    localparam int unsigned OP_W = 3;

    localparam logic [OP_W-1:0] OP_NOP = 3'd0;
    localparam logic [OP_W-1:0] OP_LDA = 3'd1;
    localparam logic [OP_W-1:0] OP_STA = 3'd2;
    localparam logic [OP_W-1:0] OP_ADD = 3'd3;
    localparam logic [OP_W-1:0] OP_SUB = 3'd4;
    localparam logic [OP_W-1:0] OP_JMP = 3'd5;
    localparam logic [OP_W-1:0] OP_JZ  = 3'd6;
    localparam logic [OP_W-1:0] OP_HLT = 3'd7;

    typedef enum logic [2:0] {
        S_FETCH,
        S_FETCH_W,
        S_DECODE,
        S_OPER,
        S_OPER_W,
        S_STORE,
        S_HALT
    } state_t;

    state_t            state;
    logic [ADDR_W-1:0] pc;
    logic [DATA_W-1:0] ir;
    logic [DATA_W-1:0] acc;
    logic              z;
    logic              c;

    logic [OP_W-1:0]   op;
    logic [ADDR_W-1:0] opnd;
    logic [DATA_W:0]   sum;
    logic [DATA_W:0]   diff;

    assign op   = ir[DATA_W-1 -: OP_W];
    assign opnd = ir[ADDR_W-1:0];

    // The extra top bit is the carry for ADD and the borrow for SUB.
    assign sum  = {1'b0, acc} + {1'b0, mem_dout_i};
    assign diff = {1'b0, acc} - {1'b0, mem_dout_i};

    // Sequencer and architectural registers
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state <= S_FETCH;
            pc    <= '0;
            ir    <= '0;
            acc   <= '0;
            z     <= 1'b0;
            c     <= 1'b0;
        end else begin
            case (state)
                S_FETCH: begin
                    if (run_i) state <= S_FETCH_W;
                end
                S_FETCH_W: begin
                    ir    <= mem_dout_i;
                    pc    <= pc + ADDR_W'(1);
                    state <= S_DECODE;
                end
                S_DECODE: begin
                    case (op)
                        OP_LDA, OP_ADD, OP_SUB: state <= S_OPER;
                        OP_STA:                 state <= S_STORE;
                        OP_JMP: begin
                            pc    <= opnd;
                            state <= S_FETCH;
                        end
                        OP_JZ: begin
                            if (z) pc <= opnd;
                            state <= S_FETCH;
                        end
                        OP_HLT:  state <= S_HALT;
                        default: state <= S_FETCH;
                    endcase
                end
                S_OPER: begin
                    state <= S_OPER_W;
                end
                S_OPER_W: begin
                    case (op)
                        OP_LDA: begin
                            acc <= mem_dout_i;
                            z   <= (mem_dout_i == '0);
                        end
                        OP_ADD: begin
                            acc <= sum[DATA_W-1:0];
                            c   <= sum[DATA_W];
                            z   <= (sum[DATA_W-1:0] == '0);
                        end
                        OP_SUB: begin
                            acc <= diff[DATA_W-1:0];
                            c   <= diff[DATA_W];
                            z   <= (diff[DATA_W-1:0] == '0);
                        end
                        default: ;
                    endcase
                    state <= S_FETCH;
                end
                S_STORE: begin
                    state <= S_FETCH;
                end
                S_HALT: begin
                    state <= S_HALT;
                end
                default: begin
                    state <= S_FETCH;
                end
            endcase
        end
    end

    // Moore decode of RAM controls; async reset drops the write enable at once
    always_comb begin
        mem_addr_o = pc;
        mem_wen_o  = 1'b0;
        case (state)
            S_OPER, S_OPER_W: mem_addr_o = opnd;
            S_STORE: begin
                mem_addr_o = opnd;
                mem_wen_o  = 1'b1;
            end
            default: ;
        endcase
    end

    assign mem_din_o = acc;
    assign acc_o     = acc;
    assign pc_o      = pc;
    assign z_o       = z;
    assign c_o       = c;
    assign halted_o  = (state == S_HALT);

endmodule

// File: tb/tb_ac_ctrl.sv
// Bench for ac_ctrl: behavioural RAM, instruction-level reference model checked
// every cycle, plus directed programs with hand-computed results.
module tb_ac_ctrl;

    localparam int unsigned AW = 5;
    localparam int unsigned DW = 8;

    logic          clk   = 1'b0;
    logic          rst_n = 1'b0;
    logic          run   = 1'b0;
    logic          load  = 1'b0;
    logic [DW-1:0] dout;
    logic [AW-1:0] addr;
    logic          wen;
    logic [DW-1:0] din;
    logic [DW-1:0] acc;
    logic [AW-1:0] pc;
    logic          z;
    logic          c;
    logic          halted;

    logic [DW-1:0] img  [32];
    logic [DW-1:0] ram  [32];
    logic [DW-1:0] mmem [32];

    int vec  = 0;
    int errs = 0;

    ac_ctrl #(.ADDR_W(AW), .DATA_W(DW)) dut (
        .clk_i      (clk),
        .rst_ni     (rst_n),
        .run_i      (run),
        .mem_dout_i (dout),
        .mem_addr_o (addr),
        .mem_wen_o  (wen),
        .mem_din_o  (din),
        .acc_o      (acc),
        .pc_o       (pc),
        .z_o        (z),
        .c_o        (c),
        .halted_o   (halted)
    );

    always #5 clk = ~clk;

    // 32x8 RAM with registered read; img is copied in while load is high
    always @(posedge clk) begin
        if (load) begin
            for (int i = 0; i < 32; i++) ram[i] <= img[i];
        end else begin
            if (wen) ram[addr] <= din;
            dout <= ram[addr];
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        vec++;
        if (act !== exp) begin
            errs++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Instruction-level model: effects computed when an instruction starts,
    // committed after its cycle count; pc shows pc+1 once the fetch completes.
    logic [AW-1:0] m_pc;
    logic [DW-1:0] m_acc;
    logic          m_z, m_c, m_halt;
    logic          busy;
    int            cnt, ncyc;
    logic [2:0]    cur_op;
    logic [AW-1:0] cur_a;
    logic [AW-1:0] n_pc;
    logic [DW-1:0] n_acc;
    logic          n_z, n_c, n_halt;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_pc = '0; m_acc = '0; m_z = 1'b0; m_c = 1'b0; m_halt = 1'b0;
            busy = 1'b0; cnt = 0; ncyc = 0;
            cur_op = '0; cur_a = '0;
            for (int i = 0; i < 32; i++) mmem[i] = img[i];
        end else if (busy) begin
            cnt++;
            if (cnt == ncyc) begin
                if (cur_op == 3'd2) mmem[cur_a] = m_acc;
                m_pc = n_pc; m_acc = n_acc; m_z = n_z; m_c = n_c; m_halt = n_halt;
                busy = 1'b0;
            end
        end else if (!m_halt && run) begin
            logic [DW-1:0] ins;
            logic [DW-1:0] d;
            int s;
            ins    = mmem[m_pc];
            cur_op = ins[7:5];
            cur_a  = ins[4:0];
            d      = mmem[cur_a];
            n_pc   = 5'(m_pc + 5'd1);
            n_acc  = m_acc; n_z = m_z; n_c = m_c; n_halt = 1'b0;
            ncyc   = 3;
            case (cur_op)
                3'd1: begin n_acc = d; n_z = (d == 8'd0); ncyc = 5; end
                3'd2: ncyc = 4;
                3'd3: begin
                    s = int'(m_acc) + int'(d);
                    n_acc = 8'(s); n_c = (s > 255); n_z = (8'(s) == 8'd0); ncyc = 5;
                end
                3'd4: begin
                    s = int'(m_acc) - int'(d) + 256;
                    n_acc = 8'(s); n_c = (m_acc < d); n_z = (8'(s) == 8'd0); ncyc = 5;
                end
                3'd5: n_pc = cur_a;
                3'd6: if (m_z) n_pc = cur_a;
                3'd7: n_halt = 1'b1;
                default: ;
            endcase
            busy = 1'b1;
            cnt  = 1;
        end
    end

    // Per-cycle comparison against the model
    always @(negedge clk) begin
        if (rst_n) begin
            logic [AW-1:0] e_pc;
            e_pc = (busy && cnt >= 2) ? 5'(m_pc + 5'd1) : m_pc;
            chk("pc",     32'(pc),     32'(e_pc));
            chk("acc",    32'(acc),    32'(m_acc));
            chk("din",    32'(din),    32'(m_acc));
            chk("z",      32'(z),      32'(m_z));
            chk("c",      32'(c),      32'(m_c));
            chk("halted", 32'(halted), 32'(m_halt));
            chk("wen",    32'(wen),    32'(busy && cur_op == 3'd2 && cnt == 3));
            if (!busy || cnt == 1)
                chk("addr_pc", 32'(addr), 32'(m_pc));
            else if (cnt >= 3)
                chk("addr_opnd", 32'(addr), 32'(cur_a));
        end
    end

    task automatic clear_img;
        for (int i = 0; i < 32; i++) img[i] = 8'h00;
    endtask

    task automatic reload;
        rst_n = 1'b0;
        run   = 1'b0;
        load  = 1'b1;
        @(posedge clk);
        @(posedge clk);
        @(negedge clk);
        load  = 1'b0;
    endtask

    task automatic release_rst;
        @(negedge clk);
        rst_n = 1'b1;
        run   = 1'b1;
    endtask

    task automatic edges(input int n);
        repeat (n) @(posedge clk);
        @(negedge clk);
    endtask

    task automatic wait_halt(input int bound);
        for (int i = 0; i < bound; i++) begin
            if (halted) break;
            @(negedge clk);
        end
        chk("halt_timeout", 32'(halted), 32'd1);
    endtask

    task automatic chk_reset_vals(input string tag);
        chk({tag, "_pc"},     32'(pc),     32'd0);
        chk({tag, "_acc"},    32'(acc),    32'd0);
        chk({tag, "_z"},      32'(z),      32'd0);
        chk({tag, "_c"},      32'(c),      32'd0);
        chk({tag, "_wen"},    32'(wen),    32'd0);
        chk({tag, "_addr"},   32'(addr),   32'd0);
        chk({tag, "_halted"}, 32'(halted), 32'd0);
        chk({tag, "_din"},    32'(din),    32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL global_timeout: got running expected finished");
        $fatal(1, "timeout");
    end

    initial begin
        // Program 1: LDA 30, ADD 31, STA 29, HLT
        clear_img;
        img[0] = 8'h3E; img[1] = 8'h7F; img[2] = 8'h5D; img[3] = 8'hE0;
        img[30] = 8'h07; img[31] = 8'h05;
        reload;
        chk_reset_vals("rst0");
        release_rst;
        edges(16);
        chk("p1_halt_early", 32'(halted), 32'd0);
        edges(1);
        chk("p1_halted", 32'(halted), 32'd1);
        chk("p1_acc",    32'(acc),    32'h0C);
        chk("p1_pc",     32'(pc),     32'd4);
        chk("p1_z",      32'(z),      32'd0);
        chk("p1_c",      32'(c),      32'd0);
        chk("p1_m29",    32'(ram[29]), 32'h0C);
        chk("p1_m29_model", 32'(ram[29]), 32'(mmem[29]));

        // Asynchronous reset from a non-trivial state
        @(negedge clk);
        #3 rst_n = 1'b0;
        #1 chk_reset_vals("rst_async");

        // Program 2: 0xFF + 0x01 sets carry and zero, JZ taken
        clear_img;
        img[0] = 8'h34; img[1] = 8'h75; img[2] = 8'hCA; img[10] = 8'hE0;
        img[20] = 8'hFF; img[21] = 8'h01;
        reload;
        release_rst;
        edges(13);
        chk("p2_pc_jz", 32'(pc),  32'd10);
        chk("p2_acc",   32'(acc), 32'h00);
        chk("p2_z",     32'(z),   32'd1);
        chk("p2_c",     32'(c),   32'd1);
        edges(2);
        chk("p2_pc_hlt", 32'(pc), 32'd11);
        edges(1);
        chk("p2_halted", 32'(halted), 32'd1);

        // Program 3: 3 - 5 borrows, JZ falls through
        clear_img;
        img[0] = 8'h34; img[1] = 8'h95; img[2] = 8'hCA; img[3] = 8'hE0;
        img[10] = 8'hE0; img[20] = 8'h03; img[21] = 8'h05;
        reload;
        release_rst;
        edges(13);
        chk("p3_pc_jz", 32'(pc), 32'd3);
        wait_halt(40);
        chk("p3_acc", 32'(acc), 32'hFE);
        chk("p3_c",   32'(c),   32'd1);
        chk("p3_z",   32'(z),   32'd0);
        chk("p3_pc",  32'(pc),  32'd4);

        // Program 4: JMP 31, NOP at 31 wraps pc, then stall
        clear_img;
        img[0] = 8'hBF; img[31] = 8'h00;
        reload;
        release_rst;
        edges(3);
        chk("p4_pc_jmp", 32'(pc), 32'd31);
        edges(2);
        chk("p4_pc_wrap", 32'(pc), 32'd0);
        edges(1);
        run = 1'b0;
        for (int i = 0; i < 10; i++) begin
            edges(1);
            chk("p4_stall_pc",   32'(pc),   32'd0);
            chk("p4_stall_addr", 32'(addr), 32'd0);
            chk("p4_stall_wen",  32'(wen),  32'd0);
        end
        run = 1'b1;
        edges(3);
        chk("p4_resume_pc", 32'(pc), 32'd31);

        // Program 5: reset while STA is writing
        clear_img;
        img[0] = 8'h34; img[1] = 8'h59; img[20] = 8'h5A; img[25] = 8'h11;
        reload;
        release_rst;
        for (int i = 0; i < 40; i++) begin
            if (wen) break;
            @(negedge clk);
        end
        chk("p5_wen",  32'(wen),  32'd1);
        chk("p5_addr", 32'(addr), 32'd25);
        chk("p5_din",  32'(din),  32'h5A);
        #2 rst_n = 1'b0;
        #1;
        chk("p5_wen_drop", 32'(wen),  32'd0);
        chk("p5_addr_rst", 32'(addr), 32'd0);
        @(posedge clk);
        @(negedge clk);
        chk("p5_m25", 32'(ram[25]), 32'h11);
        rst_n = 1'b1;
        run   = 1'b1;
        #1 chk("p5_restart_addr", 32'(addr), 32'd0);
        edges(2);
        chk("p5_restart_pc", 32'(pc), 32'd1);

        $display("== %0d vectors applied, %0d miscompares ==", vec, errs);
        $finish;
    end

endmodule
